// File: rtl/sale_terminal_pkg.sv
// -----------------------------------------------------------------------------
// sale_terminal_pkg
// Constants and types shared by the product selector, the browse controller
// and the cart/billing logic of the sale terminal.
//   NUM_ITEMS      : number of selectable product records
//   SEL_W          : width of the selector's select / item index
//   REC_W          : width of one product record
//   browse_state_t : browse controller FSM states
// -----------------------------------------------------------------------------
package sale_terminal_pkg;

    localparam int unsigned NUM_ITEMS = 13;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned REC_W     = 77;

    typedef enum logic [1:0] {
        BROWSE,
        CAPTURE,
        OFFER
    } browse_state_t;

endpackage

// File: rtl/product_browse_ctrl_if.sv
// -----------------------------------------------------------------------------
// product_browse_ctrl_if
// Bundles the selector link and the downstream record handshake.
//   mux_sel    : select driven to the product selector
//   mux_out    : record returned by the selector for mux_sel
//   item_data  : captured record offered downstream
//   item_valid : captured record available
//   out_ready  : downstream accepts item_data
// master = browse controller side, slave = selector/cart side.
// -----------------------------------------------------------------------------
interface product_browse_ctrl_if;
    import sale_terminal_pkg::*;

    logic [SEL_W-1:0] mux_sel;
    logic [REC_W-1:0] mux_out;
    logic [REC_W-1:0] item_data;
    logic             item_valid;
    logic             out_ready;

    modport master (
        output mux_sel,
        output item_data,
        output item_valid,
        input  mux_out,
        input  out_ready
    );

    modport slave (
        input  mux_sel,
        input  item_data,
        input  item_valid,
        output mux_out,
        output out_ready
    );

endinterface

// File: rtl/mod_n_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_n_updown_counter
// Wrapping modulo-N up/down counter with synchronous load.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, loads RST_VAL
//   inc_i      : step up (N-1 wraps to 0)
//   dec_i      : step down (0 wraps to N-1)
//   load_i     : load load_val_i, overrides inc/dec
//   load_val_i : value for load
//   cnt_o      : current count, always 0..N-1
// inc_i and dec_i together cancel and leave the count unchanged.
// -----------------------------------------------------------------------------
module mod_n_updown_counter #(
    parameter int unsigned N       = 13,
    parameter int unsigned W       = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MaxVal = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            cnt_d = (cnt_q == MaxVal) ? '0 : cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = (cnt_q == '0) ? MaxVal : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/product_browse_ctrl.sv
// -----------------------------------------------------------------------------
// product_browse_ctrl
// Turns next/prev/confirm button pulses into a wrapping item index for the
// product selector, captures the selected record on confirm and offers it
// downstream over a valid/ready handshake. The index returns to HOME_IDX
// after IDLE_CYCLES browse cycles without a button.
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   btn_next_i    : one-cycle pulse, advance index
//   btn_prev_i    : one-cycle pulse, step index back
//   btn_confirm_i : one-cycle pulse, capture current record
//   busy_o        : high in CAPTURE or OFFER (buttons ignored)
//   bus           : selector link + downstream handshake (master side)
// -----------------------------------------------------------------------------
module product_browse_ctrl
    import sale_terminal_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned IDLE_CYCLES   = 50_000_000,
    parameter int unsigned HOME_IDX      = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         btn_next_i,
    input  logic                         btn_prev_i,
    input  logic                         btn_confirm_i,
    output logic                         busy_o,
    product_browse_ctrl_if.master        bus
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IDLE_W   = $clog2(IDLE_CYCLES + 1);

    browse_state_t     state_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [IDLE_W-1:0] idle_q;
    logic [REC_W-1:0]  item_data_q;
    logic              item_valid_q;
    logic              busy_q;

    logic             in_browse;
    logic             any_btn;
    logic             idle_hit;
    logic             step_inc;
    logic             step_dec;
    logic [SEL_W-1:0] sel;

    always_comb begin
        in_browse = (state_q == BROWSE);
        any_btn   = btn_next_i | btn_prev_i | btn_confirm_i;
        // Timeout only fires on a button-free cycle; a pulse always wins.
        idle_hit  = in_browse && !any_btn && (idle_q == IDLE_W'(IDLE_CYCLES - 1));
        // Confirm has priority over stepping; next+prev cancel in the counter.
        step_inc  = in_browse && !btn_confirm_i && btn_next_i;
        step_dec  = in_browse && !btn_confirm_i && btn_prev_i;
    end

    mod_n_updown_counter #(
        .N       (NUM_ITEMS),
        .W       (SEL_W),
        .RST_VAL (HOME_IDX)
    ) u_index (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (step_inc),
        .dec_i      (step_dec),
        .load_i     (idle_hit),
        .load_val_i (SEL_W'(HOME_IDX)),
        .cnt_o      (sel)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= BROWSE;
            settle_q     <= '0;
            idle_q       <= '0;
            item_data_q  <= '0;
            item_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                BROWSE: begin
                    if (btn_confirm_i) begin
                        state_q  <= CAPTURE;
                        busy_q   <= 1'b1;
                        settle_q <= SETTLE_W'(SETTLE_CYCLES - 1);
                        idle_q   <= '0;
                    end else if (any_btn || idle_hit) begin
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
                CAPTURE: begin
                    // Give the selector time to settle on mux_sel before sampling.
                    if (settle_q == '0) begin
                        item_data_q  <= bus.mux_out;
                        item_valid_q <= 1'b1;
                        state_q      <= OFFER;
                    end else begin
                        settle_q <= settle_q - SETTLE_W'(1);
                    end
                end
                OFFER: begin
                    if (item_valid_q && bus.out_ready) begin
                        item_valid_q <= 1'b0;
                        state_q      <= BROWSE;
                        busy_q       <= 1'b0;
                        idle_q       <= '0;
                    end
                end
                default: begin
                    state_q      <= BROWSE;
                    item_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    idle_q       <= '0;
                end
            endcase
        end
    end

    assign bus.mux_sel    = sel;
    assign bus.item_data  = item_data_q;
    assign bus.item_valid = item_valid_q;
    assign busy_o         = busy_q;

    sel_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (int'(sel) < int'(NUM_ITEMS)))
        else $error("mux_sel out of range: %0d", sel);

endmodule

// File: tb/tb_product_browse_ctrl.sv
module tb_product_browse_ctrl;
    import sale_terminal_pkg::*;

    localparam logic [REC_W-1:0] RecA = 77'h1_2345_6789_ABCD_EF01;
    localparam logic [REC_W-1:0] RecB = 77'h0_FFFF_0000_5555_AAAA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_next = 1'b0;
    logic btn_prev = 1'b0;
    logic btn_confirm = 1'b0;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    product_browse_ctrl_if bus_if ();

    product_browse_ctrl #(
        .SETTLE_CYCLES (1),
        .IDLE_CYCLES   (8),
        .HOME_IDX      (0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .btn_next_i    (btn_next),
        .btn_prev_i    (btn_prev),
        .btn_confirm_i (btn_confirm),
        .busy_o        (busy),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             nxt;
        logic             prv;
        logic             cnf;
        logic             rdy;
        logic [REC_W-1:0] mux_out;
        logic [SEL_W-1:0] exp_sel;
        logic             exp_valid;
        logic             exp_busy;
        logic             chk_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic n, input logic p, input logic c, input logic r,
                       input logic [REC_W-1:0] mo, input int sel,
                       input logic v, input logic b, input logic cd);
        vec_t t;
        t.nxt = n; t.prv = p; t.cnf = c; t.rdy = r;
        t.mux_out = mo;
        t.exp_sel = SEL_W'(sel);
        t.exp_valid = v; t.exp_busy = b; t.chk_data = cd;
        vecs.push_back(t);
    endtask

    task automatic idle_rows(input int k, input int sel);
        for (int i = 0; i < k; i++) add(1'b0, 1'b0, 1'b0, 1'b0, RecA, sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [REC_W-1:0] got,
                         input logic [REC_W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;

        bus_if.mux_out   = RecA;
        bus_if.out_ready = 1'b0;

        // Part A: wrap forward, wrap back, next+prev cancels and clears idle.
        for (int i = 1; i <= 13; i++) add(1'b1, 1'b0, 1'b0, 1'b0, RecA, i % 13, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, RecA, 12, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, RecA, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) add(1'b1, 1'b0, 1'b0, 1'b0, RecA, i, 1'b0, 1'b0, 1'b0);
        idle_rows(4, 5);
        add(1'b1, 1'b1, 1'b0, 1'b0, RecA, 5, 1'b0, 1'b0, 1'b0);
        idle_rows(7, 5);
        idle_rows(1, 0);
        // Part B: capture at 7 with ready held high; next during CAPTURE ignored.
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b0, 1'b0, 1'b0, RecA, i, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, RecA, 7, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, RecA, 7, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, RecA, 7, 1'b0, 1'b0, 1'b0);
        // Part C: back-to-back confirm, ready low for 10 cycles while mashing next.
        add(1'b0, 1'b0, 1'b1, 1'b0, RecA, 7, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, RecA, 7, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 1'b0, 1'b0, RecB, 7, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, RecB, 7, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, RecB, 8, 1'b0, 1'b0, 1'b0);
        // Part D: idle timeout at 9, then a next on the timeout cycle wins.
        add(1'b1, 1'b0, 1'b0, 1'b0, RecA, 9, 1'b0, 1'b0, 1'b0);
        idle_rows(7, 9);
        idle_rows(1, 0);
        for (int i = 1; i <= 9; i++) add(1'b1, 1'b0, 1'b0, 1'b0, RecA, i, 1'b0, 1'b0, 1'b0);
        idle_rows(7, 9);
        add(1'b1, 1'b0, 1'b0, 1'b0, RecA, 10, 1'b0, 1'b0, 1'b0);
        idle_rows(1, 10);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.sel", REC_W'(bus_if.mux_sel), REC_W'(0));
        check("reset.valid", REC_W'(bus_if.item_valid), REC_W'(0));
        check("reset.busy", REC_W'(busy), REC_W'(0));
        check("reset.data", bus_if.item_data, '0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_next         = vecs[i].nxt;
            btn_prev         = vecs[i].prv;
            btn_confirm      = vecs[i].cnf;
            bus_if.out_ready = vecs[i].rdy;
            bus_if.mux_out   = vecs[i].mux_out;
            tick();
            check($sformatf("vec%0d.sel", i), REC_W'(bus_if.mux_sel), REC_W'(vecs[i].exp_sel));
            check($sformatf("vec%0d.valid", i), REC_W'(bus_if.item_valid),
                  REC_W'(vecs[i].exp_valid));
            check($sformatf("vec%0d.busy", i), REC_W'(busy), REC_W'(vecs[i].exp_busy));
            if (vecs[i].chk_data) check($sformatf("vec%0d.data", i), bus_if.item_data, RecA);
        end
        btn_next = 1'b0; btn_prev = 1'b0; btn_confirm = 1'b0;

        // Confirm-to-valid latency at index 10, bounded wait.
        bus_if.mux_out   = RecB;
        bus_if.out_ready = 1'b1;
        btn_confirm      = 1'b1;
        edges            = 0;
        do begin
            tick();
            btn_confirm = 1'b0;
            edges++;
        end while (!bus_if.item_valid && edges < 10);
        check("lat.edges", REC_W'(edges), REC_W'(2));
        check("lat.data", bus_if.item_data, RecB);
        tick();
        check("lat.valid_one_cycle", REC_W'(bus_if.item_valid), REC_W'(0));
        check("lat.busy_done", REC_W'(busy), REC_W'(0));

        // Reset while in OFFER drops the pending record.
        bus_if.out_ready = 1'b0;
        bus_if.mux_out   = RecA;
        btn_confirm      = 1'b1;
        tick();
        btn_confirm = 1'b0;
        tick();
        check("offer.valid", REC_W'(bus_if.item_valid), REC_W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_offer.valid", REC_W'(bus_if.item_valid), REC_W'(0));
        check("rst_offer.sel", REC_W'(bus_if.mux_sel), REC_W'(0));
        check("rst_offer.busy", REC_W'(busy), REC_W'(0));
        check("rst_offer.data", bus_if.item_data, '0);
        bus_if.out_ready = 1'b1;
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check("rst_offer.browse_sel", REC_W'(bus_if.mux_sel), REC_W'(1));
        check("rst_offer.no_valid", REC_W'(bus_if.item_valid), REC_W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/product_browse_ctrl.md
# product_browse_ctrl

Sequences the 13-entry product-record selector of the sale terminal. It converts next/prev/confirm button pulses into a wrapping item index that drives the selector's 4-bit select. On confirm, it captures the selected 77-bit record and offers it downstream over a valid/ready handshake. It sits between the button front-end (already debounced, single-cycle pulses) and the cart/billing logic.

## Interface
- NUM_ITEMS, 13, number of selectable records (indices 0..NUM_ITEMS-1)
- SEL_W, 4, select/index width; must satisfy 2^SEL_W >= NUM_ITEMS
- REC_W, 77, product record width
- SETTLE_CYCLES, 1, cycles to wait after confirm before sampling the record (>= 1)
- IDLE_CYCLES, 50_000_000, browse-idle cycles before the index returns home (>= 1)
- HOME_IDX, 0, index loaded at reset and on idle timeout

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_next  in  1  one-cycle pulse: advance index
- btn_prev  in  1  one-cycle pulse: step index back
- btn_confirm  in  1  one-cycle pulse: capture current record
- mux_out  in  REC_W  record returned by the selector for mux_sel
- mux_sel  out  SEL_W  registered select driven to the selector
- item_data  out  REC_W  captured record, stable while item_valid
- item_valid  out  1  captured record available
- out_ready  in  1  downstream accepts item_data
- busy  out  1  high in CAPTURE or OFFER; buttons ignored

## Operation
- FSM states: BROWSE, CAPTURE, OFFER. Reset: BROWSE, mux_sel=HOME_IDX, item_data=0, item_valid=0, busy=0, settle and idle counters=0.
- BROWSE, per-cycle priority:
  - btn_confirm: go to CAPTURE, load settle counter with SETTLE_CYCLES-1, index unchanged.
  - else btn_next xor btn_prev: step index. next at NUM_ITEMS-1 wraps to 0; prev at 0 wraps to NUM_ITEMS-1.
  - btn_next and btn_prev together (without confirm): no change, but counts as activity.
- Idle counter: in BROWSE, cleared on any button pulse, otherwise increments. When it reaches IDLE_CYCLES-1, mux_sel<=HOME_IDX and the counter clears. A button in that same cycle takes precedence and the counter clears.
- CAPTURE: all buttons ignored. Each cycle, if settle==0 then item_data<=mux_out, item_valid<=1, go to OFFER; else decrement settle.
- OFFER: item_data and mux_sel hold. When item_valid && out_ready, item_valid<=0 and go to BROWSE. Idle counter cleared on return.
- The idle counter does not run in CAPTURE or OFFER.
- mux_sel never exceeds NUM_ITEMS-1; any other value is an assertion failure.
- rst in any state returns all outputs to their reset values on the next edge, and any pending offer is dropped.

## Timing
- Index change is visible on mux_sel one edge after the sampled button pulse.
- Confirm sampled at edge E0: CAPTURE from E0, record sampled at edge E0+SETTLE_CYCLES, item_valid high after that edge. Default latency is 2 edges.
- Handshake completes on the edge where item_valid && out_ready. Earliest next confirm is accepted on the following edge.
- Downstream may hold out_ready high permanently. item_valid is then high for exactly one cycle.
- busy is a registered decode of state: high from the edge after confirm until the edge after the handshake.

## Structure
- Shared package sale_terminal_pkg: NUM_ITEMS, SEL_W, REC_W constants and the browse_state_t enum (BROWSE, CAPTURE, OFFER). These are shared with the selector and the cart logic.
- One sub-module, mod_n_updown_counter (parameters N, W; inputs inc, dec, load, load_val; wrapping output). It holds the index; the FSM, idle counter and capture register stay in the top.

## Test plan
- Reset, then 13 btn_next pulses: mux_sel steps 1..12 then returns to 0. One btn_prev from 0 gives 12.
- At index 5, next and prev in the same cycle: mux_sel stays 5 and the idle counter clears.
- At index 7 with mux_out=77'h1_2345_6789_ABCD_EF01 and out_ready=1, pulse confirm: item_valid high for exactly one cycle, 2 edges after confirm, with item_data equal to that value. Busy spans the sequence.
- out_ready=0 for 10 cycles after capture while mashing btn_next: item_valid and item_data hold, mux_sel stays 7. Raising out_ready completes the handshake, then a next pulse gives 8.
- IDLE_CYCLES=8 at index 9 with no buttons: mux_sel becomes 0 after 8 cycles. A repeat where btn_next lands on cycle 8 gives 10, not 0.
- Assert rst while in OFFER: next edge gives item_valid=0, mux_sel=0, busy=0, state BROWSE.
